// File: rtl/snitch_dma_event_monitor.sv
// -----------------------------------------------------------------------------
// snitch_dma_event_monitor
//
// Passive observer of the cluster DMA backend. It watches the AXI master
// channels and the backend data-buffer handshakes and produces a registered,
// one-cycle-per-occurrence event vector for the cluster performance counters.
// It also tracks outstanding read and write bursts to derive dma_busy, and
// flags counter under- and overflow as a sticky protocol error.
//
// Ports
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   clear_i                        synchronous clear of counters and err_o
//   aw_* / ar_*                    AXI address channels (valid, ready, len, size)
//   w_* / r_* / b_*                AXI data and response channels
//   buf_w_* / buf_r_*              backend data-buffer handshakes
//   backend_busy_i                 frontend/backend still has queued work
//   dma_events_o                   registered event vector
//   err_o                          sticky counter under/overflow flag
// -----------------------------------------------------------------------------

package snitch_dma_event_monitor_pkg;

    // Layout for the default DataWidth of 64 (8 strobes -> 4-bit byte count).
    typedef struct packed {
        logic       aw_stall;
        logic       ar_stall;
        logic       r_stall;
        logic       w_stall;
        logic       buf_w_stall;
        logic       buf_r_stall;
        logic       aw_done;
        logic       ar_done;
        logic       r_done;
        logic       w_done;
        logic       b_done;
        logic       dma_busy;
        logic [7:0] aw_len;
        logic [2:0] aw_size;
        logic [7:0] ar_len;
        logic [2:0] ar_size;
        logic [3:0] num_bytes_written;
    } dma_events_t;

endpackage

module snitch_dma_event_monitor #(
    parameter int unsigned DataWidth      = 64,
    parameter int unsigned MaxOutstanding = 16,
    parameter type         dma_events_t   = snitch_dma_event_monitor_pkg::dma_events_t
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clear_i,
    input  logic                   aw_valid_i,
    input  logic                   aw_ready_i,
    input  logic [7:0]             aw_len_i,
    input  logic [2:0]             aw_size_i,
    input  logic                   ar_valid_i,
    input  logic                   ar_ready_i,
    input  logic [7:0]             ar_len_i,
    input  logic [2:0]             ar_size_i,
    input  logic                   w_valid_i,
    input  logic                   w_ready_i,
    input  logic                   w_last_i,
    input  logic [DataWidth/8-1:0] w_strb_i,
    input  logic                   r_valid_i,
    input  logic                   r_ready_i,
    input  logic                   r_last_i,
    input  logic                   b_valid_i,
    input  logic                   b_ready_i,
    input  logic                   buf_w_valid_i,
    input  logic                   buf_w_ready_i,
    input  logic                   buf_r_valid_i,
    input  logic                   buf_r_ready_i,
    input  logic                   backend_busy_i,
    output dma_events_t            dma_events_o,
    output logic                   err_o
);

    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam int unsigned NbwWidth  = $clog2(StrbWidth) + 1;
    localparam int unsigned CntWidth  = $clog2(MaxOutstanding + 1);
    localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxOutstanding);

    // Number of set strobe bits; never exceeds StrbWidth so NbwWidth suffices.
    function automatic logic [NbwWidth-1:0] popcount(input logic [StrbWidth-1:0] v);
        logic [NbwWidth-1:0] c;
        c = '0;
        for (int i = 0; i < StrbWidth; i++) begin
            c = c + NbwWidth'(v[i]);
        end
        return c;
    endfunction

    // Saturating up/down step. Returns {error, next_count}; a simultaneous
    // increment and decrement cancels out and can never raise an error.
    function automatic logic [CntWidth:0] cnt_step(input logic [CntWidth-1:0] cnt,
                                                   input logic inc,
                                                   input logic dec);
        logic                err;
        logic [CntWidth-1:0] nxt;
        err = 1'b0;
        nxt = cnt;
        case ({inc, dec})
            2'b10: begin
                if (cnt == CntMax) begin
                    err = 1'b1;
                end else begin
                    nxt = cnt + CntWidth'(1);
                end
            end
            2'b01: begin
                if (cnt == '0) begin
                    err = 1'b1;
                end else begin
                    nxt = cnt - CntWidth'(1);
                end
            end
            default: begin
                nxt = cnt;
            end
        endcase
        return {err, nxt};
    endfunction

    logic w_aw_hs, w_ar_hs, w_wd_hs, w_rd_hs, w_b_hs;
    logic w_rd_last_hs;

    assign w_aw_hs      = aw_valid_i & aw_ready_i;
    assign w_ar_hs      = ar_valid_i & ar_ready_i;
    assign w_wd_hs      = w_valid_i & w_ready_i;
    assign w_rd_hs      = r_valid_i & r_ready_i;
    assign w_b_hs       = b_valid_i & b_ready_i;
    assign w_rd_last_hs = w_rd_hs & r_last_i;

    // W beat boundaries carry no information for the counters or events.
    logic w_unused_s;
    assign w_unused_s = w_last_i;

    logic [CntWidth-1:0] r_wr_cnt, r_rd_cnt;
    logic                r_err;
    dma_events_t         r_events;

    logic [CntWidth:0]   w_wr_step, w_rd_step;
    logic [CntWidth-1:0] w_wr_cnt_next, w_rd_cnt_next;
    logic                w_err_next;
    dma_events_t         w_events_next;

    // Next-state counters and error; clear overrides any same-cycle handshake.
    always_comb begin
        w_wr_step = cnt_step(r_wr_cnt, w_aw_hs, w_b_hs);
        w_rd_step = cnt_step(r_rd_cnt, w_ar_hs, w_rd_last_hs);
        if (clear_i) begin
            w_wr_cnt_next = '0;
            w_rd_cnt_next = '0;
            w_err_next    = 1'b0;
        end else begin
            w_wr_cnt_next = w_wr_step[CntWidth-1:0];
            w_rd_cnt_next = w_rd_step[CntWidth-1:0];
            w_err_next    = r_err | w_wr_step[CntWidth] | w_rd_step[CntWidth];
        end
    end

    // Next-cycle event vector; busy looks at the post-update counters.
    always_comb begin
        w_events_next             = '0;
        w_events_next.aw_stall    = aw_valid_i & ~aw_ready_i;
        w_events_next.ar_stall    = ar_valid_i & ~ar_ready_i;
        w_events_next.r_stall     = r_valid_i & ~r_ready_i;
        w_events_next.w_stall     = w_valid_i & ~w_ready_i;
        w_events_next.buf_w_stall = buf_w_valid_i & ~buf_w_ready_i;
        w_events_next.buf_r_stall = buf_r_valid_i & ~buf_r_ready_i;
        w_events_next.aw_done     = w_aw_hs;
        w_events_next.ar_done     = w_ar_hs;
        w_events_next.r_done      = w_rd_hs;
        w_events_next.w_done      = w_wd_hs;
        w_events_next.b_done      = w_b_hs;
        w_events_next.dma_busy    = (w_wr_cnt_next != '0) | (w_rd_cnt_next != '0)
                                    | backend_busy_i;
        if (w_aw_hs) begin
            w_events_next.aw_len  = aw_len_i;
            w_events_next.aw_size = aw_size_i;
        end else begin
            w_events_next.aw_len  = 8'd0;
            w_events_next.aw_size = 3'd0;
        end
        if (w_ar_hs) begin
            w_events_next.ar_len  = ar_len_i;
            w_events_next.ar_size = ar_size_i;
        end else begin
            w_events_next.ar_len  = 8'd0;
            w_events_next.ar_size = 3'd0;
        end
        if (w_wd_hs) begin
            w_events_next.num_bytes_written = popcount(w_strb_i);
        end else begin
            w_events_next.num_bytes_written = '0;
        end
    end

    // State and output registers; reset drops all outstanding bookkeeping.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_cnt <= '0;
            r_rd_cnt <= '0;
            r_err    <= 1'b0;
            r_events <= '0;
        end else begin
            r_wr_cnt <= w_wr_cnt_next;
            r_rd_cnt <= w_rd_cnt_next;
            r_err    <= w_err_next;
            r_events <= w_events_next;
        end
    end

    assign dma_events_o = r_events;
    assign err_o        = r_err;

endmodule

// File: tb/tb_snitch_dma_event_monitor.sv
module tb_snitch_dma_event_monitor;
    import snitch_dma_event_monitor_pkg::*;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       clear_i;
    logic       aw_valid_i, aw_ready_i, ar_valid_i, ar_ready_i;
    logic [7:0] aw_len_i, ar_len_i;
    logic [2:0] aw_size_i, ar_size_i;
    logic       w_valid_i, w_ready_i, w_last_i;
    logic [7:0] w_strb_i;
    logic       r_valid_i, r_ready_i, r_last_i, b_valid_i, b_ready_i;
    logic       buf_w_valid_i, buf_w_ready_i, buf_r_valid_i, buf_r_ready_i;
    logic       backend_busy_i;
    dma_events_t dma_events_o;
    logic        err_o;

    int n_checks = 0;
    int n_pass   = 0;

    dma_events_t exp_ev_q[$];
    logic        exp_err_q[$];
    dma_events_t e;

    always #5 clk_i = ~clk_i;

    snitch_dma_event_monitor #(.DataWidth(64), .MaxOutstanding(16)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
        .aw_valid_i(aw_valid_i), .aw_ready_i(aw_ready_i), .aw_len_i(aw_len_i), .aw_size_i(aw_size_i),
        .ar_valid_i(ar_valid_i), .ar_ready_i(ar_ready_i), .ar_len_i(ar_len_i), .ar_size_i(ar_size_i),
        .w_valid_i(w_valid_i), .w_ready_i(w_ready_i), .w_last_i(w_last_i), .w_strb_i(w_strb_i),
        .r_valid_i(r_valid_i), .r_ready_i(r_ready_i), .r_last_i(r_last_i),
        .b_valid_i(b_valid_i), .b_ready_i(b_ready_i),
        .buf_w_valid_i(buf_w_valid_i), .buf_w_ready_i(buf_w_ready_i),
        .buf_r_valid_i(buf_r_valid_i), .buf_r_ready_i(buf_r_ready_i),
        .backend_busy_i(backend_busy_i),
        .dma_events_o(dma_events_o), .err_o(err_o)
    );

    task automatic check_ev(input string name, input dma_events_t got, input dma_events_t exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s events got=%h exp=%h", name, got, exp);
    endtask

    task automatic check_bit(input string name, input logic got, input logic exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%b exp=%b", name, got, exp);
    endtask

    // Monitor: pops one expectation per registered output cycle.
    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            if (exp_ev_q.size() > 0) begin
                check_ev("sb_events", dma_events_o, exp_ev_q.pop_front());
                check_bit("sb_err", err_o, exp_err_q.pop_front());
            end
        end
    end

    task automatic idle();
        clear_i = 1'b0;
        aw_valid_i = 1'b0; aw_ready_i = 1'b0; aw_len_i = 8'd0; aw_size_i = 3'd0;
        ar_valid_i = 1'b0; ar_ready_i = 1'b0; ar_len_i = 8'd0; ar_size_i = 3'd0;
        w_valid_i = 1'b0; w_ready_i = 1'b0; w_last_i = 1'b0; w_strb_i = 8'h00;
        r_valid_i = 1'b0; r_ready_i = 1'b0; r_last_i = 1'b0;
        b_valid_i = 1'b0; b_ready_i = 1'b0;
        buf_w_valid_i = 1'b0; buf_w_ready_i = 1'b0;
        buf_r_valid_i = 1'b0; buf_r_ready_i = 1'b0;
        backend_busy_i = 1'b0;
    endtask

    // Inputs are already set; queue the expected outcome and advance one cycle.
    task automatic step(input dma_events_t ex, input logic er);
        exp_ev_q.push_back(ex);
        exp_err_q.push_back(er);
        @(negedge clk_i);
    endtask

    function automatic dma_events_t ev0(input logic busy);
        dma_events_t t;
        t = '0;
        t.dma_busy = busy;
        return t;
    endfunction

    logic [7:0] strbs [4] = '{8'hFF, 8'h0F, 8'h01, 8'h00};
    logic [3:0] nbw   [4] = '{4'd8, 4'd4, 4'd1, 4'd0};

    initial begin
        idle();
        rst_ni = 1'b0;
        repeat (3) @(negedge clk_i);
        check_ev("in_reset", dma_events_o, '0);
        rst_ni = 1'b1;

        // Idle after reset release: everything stays 0.
        for (int i = 0; i < 10; i++) step(ev0(1'b0), 1'b0);

        // AW handshake len=3 size=3.
        aw_valid_i = 1'b1; aw_ready_i = 1'b1; aw_len_i = 8'd3; aw_size_i = 3'd3;
        e = ev0(1'b1); e.aw_done = 1'b1; e.aw_len = 8'd3; e.aw_size = 3'd3;
        step(e, 1'b0);
        idle();
        step(ev0(1'b1), 1'b0);

        // Four W beats with varying strobes.
        for (int i = 0; i < 4; i++) begin
            w_valid_i = 1'b1; w_ready_i = 1'b1; w_strb_i = strbs[i]; w_last_i = (i == 3);
            e = ev0(1'b1); e.w_done = 1'b1; e.num_bytes_written = nbw[i];
            step(e, 1'b0);
        end
        idle();

        // AW stalled three cycles, then accepted (wr_cnt 1 -> 2).
        aw_valid_i = 1'b1; aw_len_i = 8'd0; aw_size_i = 3'd2;
        for (int i = 0; i < 3; i++) begin
            e = ev0(1'b1); e.aw_stall = 1'b1;
            step(e, 1'b0);
        end
        aw_ready_i = 1'b1;
        e = ev0(1'b1); e.aw_done = 1'b1; e.aw_size = 3'd2;
        step(e, 1'b0);
        idle();
        b_valid_i = 1'b1; b_ready_i = 1'b1;
        e = ev0(1'b1); e.b_done = 1'b1;
        step(e, 1'b0);                       // wr_cnt 2 -> 1

        // AW and B in the same cycle: wr_cnt stays 1.
        aw_valid_i = 1'b1; aw_ready_i = 1'b1; aw_len_i = 8'd1; aw_size_i = 3'd1;
        e = ev0(1'b1); e.aw_done = 1'b1; e.b_done = 1'b1; e.aw_len = 8'd1; e.aw_size = 3'd1;
        step(e, 1'b0);
        idle();
        b_valid_i = 1'b1; b_ready_i = 1'b1;
        e = ev0(1'b0); e.b_done = 1'b1;
        step(e, 1'b0);                       // wr_cnt 1 -> 0, busy drops

        // Underflow: B with nothing outstanding sets a sticky error.
        e = ev0(1'b0); e.b_done = 1'b1;
        step(e, 1'b1);
        idle();
        step(ev0(1'b0), 1'b1);
        step(ev0(1'b0), 1'b1);
        clear_i = 1'b1;
        step(ev0(1'b0), 1'b0);
        idle();

        // Clear together with an AW handshake: clear wins, busy stays low.
        clear_i = 1'b1;
        aw_valid_i = 1'b1; aw_ready_i = 1'b1; aw_len_i = 8'd5; aw_size_i = 3'd2;
        e = ev0(1'b0); e.aw_done = 1'b1; e.aw_len = 8'd5; e.aw_size = 3'd2;
        step(e, 1'b0);
        idle();
        step(ev0(1'b0), 1'b0);

        // All stall sources at once, plus backend busy.
        aw_valid_i = 1'b1; ar_valid_i = 1'b1; w_valid_i = 1'b1; r_valid_i = 1'b1;
        buf_w_valid_i = 1'b1; buf_r_valid_i = 1'b1; backend_busy_i = 1'b1;
        e = ev0(1'b1);
        e.aw_stall = 1'b1; e.ar_stall = 1'b1; e.w_stall = 1'b1; e.r_stall = 1'b1;
        e.buf_w_stall = 1'b1; e.buf_r_stall = 1'b1;
        step(e, 1'b0);
        idle();
        step(ev0(1'b0), 1'b0);

        // Overflow: the 17th outstanding read raises the error.
        ar_valid_i = 1'b1; ar_ready_i = 1'b1;
        for (int i = 0; i < 17; i++) begin
            e = ev0(1'b1); e.ar_done = 1'b1;
            step(e, (i == 16));
        end
        idle();
        clear_i = 1'b1;
        step(ev0(1'b0), 1'b1 ^ 1'b1);
        idle();

        // Reset in the middle of a read burst.
        ar_valid_i = 1'b1; ar_ready_i = 1'b1; ar_len_i = 8'd7; ar_size_i = 3'd3;
        e = ev0(1'b1); e.ar_done = 1'b1; e.ar_len = 8'd7; e.ar_size = 3'd3;
        step(e, 1'b0);
        idle();
        r_valid_i = 1'b1; r_ready_i = 1'b1;
        e = ev0(1'b1); e.r_done = 1'b1;
        step(e, 1'b0);
        rst_ni = 1'b0;
        #1;
        check_ev("async_reset", dma_events_o, '0);
        check_bit("async_reset_err", err_o, 1'b0);
        idle();
        @(negedge clk_i);
        rst_ni = 1'b1;
        // Last beat of the lost burst underflows rd_cnt.
        r_valid_i = 1'b1; r_ready_i = 1'b1; r_last_i = 1'b1;
        e = ev0(1'b0); e.r_done = 1'b1;
        step(e, 1'b1);
        idle();
        clear_i = 1'b1;
        step(ev0(1'b0), 1'b0);
        idle();

        // Let the monitor drain; a leftover entry counts as a failure.
        repeat (2) @(negedge clk_i);
        n_checks++;
        if (exp_ev_q.size() == 0) n_pass++;
        else $display("FAIL sb_drain pending=%0d exp=0", exp_ev_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
